// File: rtl/zx_vram_pkg.sv
// ---------------------------------------------------------------------------
// zx_vram_pkg
//
// Shared definitions for the ZX display VRAM arbiter:
//   - the default CPU address window that maps onto video RAM
//   - video RAM geometry (bitmap size, attribute area base offset)
//   - the arbiter FSM state type
//   - the CPU write-buffer entry layout
//   - a small helper that tests a CPU address against an inclusive window
// ---------------------------------------------------------------------------
package zx_vram_pkg;

    // Default CPU window onto VRAM (inclusive on both ends).
    localparam logic [15:0] VRAM_BASE = 16'h4000;
    localparam logic [15:0] VRAM_TOP  = 16'h5AFF;

    // 6144 bitmap bytes followed by 768 attribute bytes.
    localparam int unsigned VRAM_SIZE = 6912;
    localparam logic [12:0] ATTR_BASE = 13'h1800;

    // Width of a VRAM offset as seen on the memory port.
    localparam int unsigned OFFSET_W  = 13;

    // Memory-port owner for the current cycle.
    //   ST_VPIX  : pixel byte address on the port, request acknowledged
    //   ST_VATTR : attribute byte address on the port, pixel byte returns
    //   ST_VCAP  : attribute byte returns, port idle
    //   ST_CWR   : one buffered CPU write drains to VRAM
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VPIX  = 3'd1,
        ST_VATTR = 3'd2,
        ST_VCAP  = 3'd3,
        ST_CWR   = 3'd4
    } state_t;

    // One buffered CPU write: VRAM offset plus data byte.
    typedef struct packed {
        logic [OFFSET_W-1:0] offset;
        logic [7:0]          data;
    } wr_entry_t;

    // True when addr lies in base..top inclusive.
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] top);
        return (addr >= base) && (addr <= top);
    endfunction

endpackage : zx_vram_pkg

// File: rtl/zx_wr_fifo.sv
// ---------------------------------------------------------------------------
// zx_wr_fifo
//
// Synchronous FIFO that buffers CPU writes until the arbiter grants them a
// memory slot. Full/empty come from an occupancy counter. A push while full
// is accepted only when a pop happens in the same cycle; the head is read
// combinationally before the edge, so the slot being vacated can be reused.
//
// Parameters
//   DEPTH  number of entries (power of two, 2..16)
//   WIDTH  entry width in bits
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst    synchronous active-high reset, empties the FIFO
//   i_push   write request (ignored when full unless popping)
//   i_pop    read request (ignored when empty)
//   i_wdata  entry to push
//   o_rdata  head entry (valid while !o_empty)
//   o_full   DEPTH entries held
//   o_empty  no entries held
//   o_count  current occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module zx_wr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 21,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read once
    // r_count says it was written, so clearing it would just cost flops.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule : zx_wr_fifo

// File: rtl/zx_vram_arbiter.sv
// ---------------------------------------------------------------------------
// zx_vram_arbiter
//
// Shares one single-port VRAM between the video scanner and buffered Z80
// writes. A video cell fetch takes three cycles (pixel read, attribute read,
// attribute capture) and its bytes are presented one cycle later. CPU writes
// that fall inside the VRAM window are queued and drained one per CWR slot;
// after a fetch finds writes pending, exactly one write runs before the next
// fetch, so the CPU is never starved by a continuously requesting scanner.
//
// Parameters
//   FIFO_DEPTH  CPU write entries buffered (power of two, 2..16)
//   VRAM_BASE   first CPU address mapped to VRAM
//   VRAM_TOP    last CPU address mapped to VRAM
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_vid_req        scanner requests one cell fetch; held until o_vid_ack
//   i_vid_pix_addr   VRAM offset of the pixel byte
//   i_vid_attr_addr  VRAM offset of the attribute byte
//   o_vid_ack        one-cycle pulse, request accepted, addresses sampled
//   o_vid_pix        fetched pixel byte, valid with o_vid_valid
//   o_vid_attr       fetched attribute byte, valid with o_vid_valid
//   o_vid_valid      one-cycle pulse, fetched bytes valid
//   i_cpu_wr_stb     one-cycle pulse, synchronized Z80 write detected
//   i_cpu_addr       Z80 write address
//   i_cpu_data       Z80 write data
//   o_cpu_overflow   sticky, an in-window write was dropped
//   o_wr_toggle      inverts on every VRAM write performed
//   o_mem_addr       VRAM address
//   o_mem_we         VRAM write enable
//   o_mem_wdata      VRAM write data
//   i_mem_rdata      VRAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module zx_vram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] VRAM_BASE  = zx_vram_pkg::VRAM_BASE,
    parameter logic [15:0] VRAM_TOP   = zx_vram_pkg::VRAM_TOP
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_vid_req,
    input  logic [12:0] i_vid_pix_addr,
    input  logic [12:0] i_vid_attr_addr,
    output logic        o_vid_ack,
    output logic [7:0]  o_vid_pix,
    output logic [7:0]  o_vid_attr,
    output logic        o_vid_valid,

    input  logic        i_cpu_wr_stb,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_data,
    output logic        o_cpu_overflow,
    output logic        o_wr_toggle,

    output logic [12:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata
);

    import zx_vram_pkg::*;

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = $bits(wr_entry_t);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t      r_state;
    logic [12:0] r_attr_addr;
    logic [7:0]  r_vid_pix;
    logic [7:0]  r_vid_attr;
    logic        r_vid_valid;
    logic        r_overflow;
    logic        r_wr_toggle;

    // ---------------------------------------------------------------------
    // Combinational nets
    // ---------------------------------------------------------------------
    state_t               w_next_state;
    logic                 w_in_range;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_drop;
    wr_entry_t            w_push_entry;
    wr_entry_t            w_head;
    logic [ENTRY_W-1:0]   w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;

    // ---------------------------------------------------------------------
    // CPU write capture
    // ---------------------------------------------------------------------
    assign w_in_range          = in_window(i_cpu_addr, VRAM_BASE, VRAM_TOP);
    assign w_push_req          = i_cpu_wr_stb && w_in_range;
    assign w_push_entry.offset = OFFSET_W'(i_cpu_addr - VRAM_BASE);
    assign w_push_entry.data   = i_cpu_data;

    // A pop only ever happens in CWR, which is entered with the FIFO
    // non-empty, so w_pop is the real pop that frees a slot this cycle.
    assign w_drop = w_push_req && w_fifo_full && !w_pop;

    zx_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push_req),
        .i_pop   (w_pop),
        .i_wdata (w_push_entry),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_head = wr_entry_t'(w_fifo_rdata);

    // ---------------------------------------------------------------------
    // Arbiter FSM: next state and memory-port drive
    // ---------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        o_vid_ack    = 1'b0;
        o_mem_addr   = '0;
        o_mem_we     = 1'b0;
        o_mem_wdata  = '0;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_vid_req)          w_next_state = ST_VPIX;
                else if (!w_fifo_empty) w_next_state = ST_CWR;
            end

            ST_VPIX: begin
                o_vid_ack    = 1'b1;
                o_mem_addr   = i_vid_pix_addr;
                w_next_state = ST_VATTR;
            end

            ST_VATTR: begin
                o_mem_addr   = r_attr_addr;
                w_next_state = ST_VCAP;
            end

            ST_VCAP: begin
                // Pending writes get the slot before the scanner's next fetch.
                if (!w_fifo_empty)  w_next_state = ST_CWR;
                else if (i_vid_req) w_next_state = ST_VPIX;
                else                w_next_state = ST_IDLE;
            end

            ST_CWR: begin
                o_mem_addr  = w_head.offset;
                o_mem_wdata = w_head.data;
                o_mem_we    = 1'b1;
                w_pop       = 1'b1;
                // Occupancy is the pre-pop count; more than one entry means
                // something is still queued after this write.
                if (i_vid_req)                      w_next_state = ST_VPIX;
                else if (w_fifo_count > CNT_W'(1))  w_next_state = ST_CWR;
                else                                w_next_state = ST_IDLE;
            end

            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State, fetch data path and status flags
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_attr_addr <= '0;
            r_vid_pix   <= '0;
            r_vid_attr  <= '0;
            r_vid_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_wr_toggle <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // The scanner may move its addresses once acked, so the
            // attribute address is held for the following cycle.
            if (r_state == ST_VPIX) r_attr_addr <= i_vid_attr_addr;

            // Read data trails the address by one cycle.
            if (r_state == ST_VATTR) r_vid_pix  <= i_mem_rdata;
            if (r_state == ST_VCAP)  r_vid_attr <= i_mem_rdata;

            r_vid_valid <= (r_state == ST_VCAP);

            if (w_drop) r_overflow  <= 1'b1;
            if (w_pop)  r_wr_toggle <= ~r_wr_toggle;
        end
    end

    assign o_vid_pix      = r_vid_pix;
    assign o_vid_attr     = r_vid_attr;
    assign o_vid_valid    = r_vid_valid;
    assign o_cpu_overflow = r_overflow;
    assign o_wr_toggle    = r_wr_toggle;

endmodule : zx_vram_arbiter

// File: tb/tb_zx_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zx_vram_arbiter
//
// Drives directed scenarios followed by randomized scanner/CPU traffic. A
// behavioural model tracks what the memory port is used for each cycle, a
// queue of buffered writes and a shadow copy of VRAM; its predictions are
// compared with the DUT every cycle. Directed scenarios add hand-computed
// literal expectations.
// ---------------------------------------------------------------------------
module tb_zx_vram_arbiter;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h4000;
    localparam logic [15:0] TOP   = 16'h5AFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vid_req = 1'b0;
    logic [12:0] vid_pix_addr = '0;
    logic [12:0] vid_attr_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_pix;
    logic [7:0]  vid_attr;
    logic        vid_valid;
    logic        cpu_wr_stb = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_overflow;
    logic        wr_toggle;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    zx_vram_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .VRAM_BASE  (BASE),
        .VRAM_TOP   (TOP)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_vid_req       (vid_req),
        .i_vid_pix_addr  (vid_pix_addr),
        .i_vid_attr_addr (vid_attr_addr),
        .o_vid_ack       (vid_ack),
        .o_vid_pix       (vid_pix),
        .o_vid_attr      (vid_attr),
        .o_vid_valid     (vid_valid),
        .i_cpu_wr_stb    (cpu_wr_stb),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_data      (cpu_data),
        .o_cpu_overflow  (cpu_overflow),
        .o_wr_toggle     (wr_toggle),
        .o_mem_addr      (mem_addr),
        .o_mem_we        (mem_we),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 5));
    endfunction

    // Physical VRAM on the DUT memory port: 1-cycle read latency.
    logic [7:0] vram [8192];
    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            mem_rdata <= vram[mem_addr];
            if (mem_we) vram[mem_addr] = mem_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: what the memory port does each cycle
    // ---------------------------------------------------------------------
    typedef enum int {P_IDLE, P_READ_PIX, P_READ_ATTR, P_GAP, P_WRITE} port_use_e;

    port_use_e   m_use;
    logic [20:0] m_q [$];
    logic [7:0]  m_ram [8192];
    logic [12:0] m_pix_addr, m_attr_addr;
    logic [7:0]  m_pix, m_attr;
    logic        m_valid, m_ovf, m_tog;
    bit          m_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 8192; i++) m_ram[i] = init_byte(i);
        m_q.delete();
        m_use = P_IDLE;
        m_pix = '0; m_attr = '0;
        m_pix_addr = '0; m_attr_addr = '0;
        m_valid = 1'b0; m_ovf = 1'b0; m_tog = 1'b0;
        m_en = 1'b1;
    endtask

    // Compare this cycle's outputs, then advance the model across the edge.
    task automatic model_cycle();
        int          n;
        logic [20:0] head;
        port_use_e   nxt;
        if (!m_en) return;

        check("m_ack", vid_ack, m_use == P_READ_PIX);
        check("m_we", mem_we, m_use == P_WRITE);
        if (m_use == P_IDLE)      check("m_addr_idle", mem_addr, 0);
        if (m_use == P_READ_PIX)  check("m_addr_pix", mem_addr, vid_pix_addr);
        if (m_use == P_READ_ATTR) check("m_addr_attr", mem_addr, m_attr_addr);
        if (m_use == P_WRITE) begin
            check("m_addr_wr", mem_addr, m_q[0][20:8]);
            check("m_wdata", mem_wdata, m_q[0][7:0]);
        end
        check("m_valid", vid_valid, m_valid);
        if (m_valid) begin
            check("m_pix", vid_pix, m_pix);
            check("m_attr", vid_attr, m_attr);
        end
        check("m_ovf", cpu_overflow, m_ovf);
        check("m_tog", wr_toggle, m_tog);

        n = m_q.size();
        if (m_use == P_WRITE) begin
            head = m_q.pop_front();
            m_ram[head[20:8]] = head[7:0];
            m_tog = ~m_tog;
        end
        if (cpu_wr_stb && cpu_addr >= BASE && cpu_addr <= TOP) begin
            if (n < DEPTH || m_use == P_WRITE) m_q.push_back({13'(cpu_addr - BASE), cpu_data});
            else                               m_ovf = 1'b1;
        end

        nxt = P_IDLE;
        case (m_use)
            P_IDLE:      nxt = vid_req ? P_READ_PIX : (n > 0 ? P_WRITE : P_IDLE);
            P_READ_PIX: begin
                m_pix_addr  = vid_pix_addr;
                m_attr_addr = vid_attr_addr;
                nxt = P_READ_ATTR;
            end
            P_READ_ATTR: begin
                m_pix = m_ram[m_pix_addr];
                nxt = P_GAP;
            end
            P_GAP: begin
                m_attr = m_ram[m_attr_addr];
                nxt = (n > 0) ? P_WRITE : (vid_req ? P_READ_PIX : P_IDLE);
            end
            P_WRITE:     nxt = vid_req ? P_READ_PIX : (n > 1 ? P_WRITE : P_IDLE);
            default:     nxt = P_IDLE;
        endcase
        m_valid = (m_use == P_GAP);

        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0; m_tog = 1'b0; m_valid = 1'b0;
            m_pix = '0; m_attr = '0;
            nxt = P_IDLE;
        end
        m_use = nxt;
    endtask

    // Snapshot of the last cycle's outputs for directed literal checks.
    logic        s_ack, s_valid, s_we, s_ovf, s_tog;
    logic [12:0] s_addr;
    logic [7:0]  s_wdata, s_pix, s_attr;

    task automatic cycle();
        @(negedge clk);
        s_ack = vid_ack; s_valid = vid_valid; s_we = mem_we; s_ovf = cpu_overflow;
        s_tog = wr_toggle; s_addr = mem_addr; s_wdata = mem_wdata;
        s_pix = vid_pix; s_attr = vid_attr;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic new_video_addrs();
        vid_pix_addr  = 13'($urandom_range(0, 6143));
        vid_attr_addr = 13'h1800 + 13'($urandom_range(0, 767));
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int  wr_cnt;
        int  valid_cnt;
        bit  found;
        int  sel;

        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, RST still asserted this cycle.
        cycle();
        check("rst_ack", s_ack, 0);
        check("rst_valid", s_valid, 0);
        check("rst_we", s_we, 0);
        check("rst_addr", s_addr, 0);
        check("rst_pix", s_pix, 0);
        check("rst_attr", s_attr, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_tog", s_tog, 0);
        rst = 1'b0;
        cycle(); cycle();

        // Single write from idle lands within two cycles.
        cpu_wr_stb = 1'b1; cpu_addr = 16'h4000; cpu_data = 8'hA5;
        cycle();
        cpu_wr_stb = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            if (s_we) begin
                found = 1'b1;
                check("wr0_addr", s_addr, 13'h0000);
                check("wr0_data", s_wdata, 8'hA5);
                break;
            end
        end
        check("wr0_seen", found, 1);
        cycle();
        check("wr0_toggle", s_tog, 1);

        // Out-of-window strobes are ignored.
        wr_cnt = 0;
        cpu_wr_stb = 1'b1; cpu_addr = 16'h3FFF; cpu_data = 8'h11;
        cycle(); wr_cnt += int'(s_we);
        cpu_addr = 16'h5B00; cpu_data = 8'h22;
        cycle(); wr_cnt += int'(s_we);
        cpu_wr_stb = 1'b0;
        for (int k = 0; k < 4; k++) begin cycle(); wr_cnt += int'(s_we); end
        check("oob_no_write", wr_cnt, 0);
        check("oob_no_ovf", s_ovf, 0);

        // Cell fetch of bytes placed by CPU writes: FF at 0x0000, 47 at 0x1800.
        cpu_wr_stb = 1'b1; cpu_addr = 16'h4000; cpu_data = 8'hFF;
        cycle();
        cpu_addr = 16'h5800; cpu_data = 8'h47;
        cycle();
        cpu_wr_stb = 1'b0;
        repeat (6) cycle();
        vid_req = 1'b1; vid_pix_addr = 13'h0000; vid_attr_addr = 13'h1800;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (s_ack) begin found = 1'b1; break; end
        end
        check("fetch_ack_seen", found, 1);
        vid_req = 1'b0;
        cycle(); check("fetch_n1_valid", s_valid, 0);
        cycle(); check("fetch_n2_valid", s_valid, 0);
        cycle(); check("fetch_n3_valid", s_valid, 1);
        check("fetch_pix", s_pix, 8'hFF);
        check("fetch_attr", s_attr, 8'h47);
        repeat (2) cycle();

        // Continuous scanner traffic with three writes: all drain promptly.
        vid_req = 1'b1; new_video_addrs();
        for (int k = 0; k < 6; k++) begin cycle(); if (s_ack) new_video_addrs(); end
        wr_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            cpu_wr_stb = (k < 3);
            cpu_addr   = BASE + 16'($urandom_range(0, 6911));
            cpu_data   = 8'($urandom);
            cycle();
            wr_cnt += int'(s_we);
            if (s_ack) new_video_addrs();
        end
        cpu_wr_stb = 1'b0;
        check("busy_3_writes", wr_cnt, 3);
        check("busy_no_ovf", s_ovf, 0);

        // Six back-to-back writes against a busy scanner overflow a depth-4 FIFO.
        wr_cnt = 0;
        for (int k = 0; k < 34; k++) begin
            cpu_wr_stb = (k < 6);
            cpu_addr   = BASE + 16'($urandom_range(0, 31));
            cpu_data   = 8'($urandom);
            cycle();
            wr_cnt += int'(s_we);
            if (s_ack) new_video_addrs();
        end
        cpu_wr_stb = 1'b0;
        check("burst_ovf", s_ovf, 1);
        check("burst_accepted_4_or_5", (wr_cnt == 4) || (wr_cnt == 5), 1);
        vid_req = 1'b0;
        repeat (4) cycle();

        // Reset during the attribute read abandons the fetch and queued write.
        vid_req = 1'b1; new_video_addrs();
        cpu_wr_stb = 1'b1; cpu_addr = 16'h4100; cpu_data = 8'h5C;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            cpu_wr_stb = 1'b0;
            if (s_ack) begin found = 1'b1; break; end
        end
        check("rstmid_ack_seen", found, 1);
        vid_req = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        valid_cnt = 0; wr_cnt = 0;
        cycle();
        check("rstmid_idle_addr", s_addr, 0);
        check("rstmid_idle_ack", s_ack, 0);
        valid_cnt += int'(s_valid); wr_cnt += int'(s_we);
        for (int k = 0; k < 5; k++) begin
            cycle(); valid_cnt += int'(s_valid); wr_cnt += int'(s_we);
        end
        check("rstmid_no_valid", valid_cnt, 0);
        check("rstmid_fifo_empty", wr_cnt, 0);
        check("rstmid_ovf_clear", s_ovf, 0);

        // Randomized traffic, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!vid_req || s_ack) begin
                vid_req = ($urandom_range(0, 3) != 0);
                new_video_addrs();
                if ($urandom_range(0, 3) == 0) vid_pix_addr = 13'($urandom_range(0, 15));
            end
            cpu_wr_stb = ($urandom_range(0, 2) == 0);
            cpu_data   = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       cpu_addr = 16'h3FFF;
                1:       cpu_addr = 16'h4000;
                2:       cpu_addr = 16'h5AFF;
                3:       cpu_addr = 16'h5B00;
                4:       cpu_addr = 16'($urandom);
                5, 6:    cpu_addr = BASE + 16'($urandom_range(0, 15));
                default: cpu_addr = BASE + 16'($urandom_range(0, 6911));
            endcase
            cycle();
        end
        rst = 1'b0; cpu_wr_stb = 1'b0; vid_req = 1'b0;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_zx_vram_arbiter

// File: doc/zx_vram_arbiter.md
ZX_VRAM_ARBITER -- requirements
Module: zx_vram_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the number of CPU write entries buffered (power of two, 2..16).
REQ-002 The block SHALL have parameter VRAM_BASE, default 16'h4000, the first CPU address mapped to VRAM.
REQ-003 The block SHALL have parameter VRAM_TOP, default 16'h5AFF, the last CPU address mapped to VRAM.
REQ-004 CLK  in  1  single system clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 vid_req  in  1  video scanner requests one cell fetch (pixel byte + attribute byte); held until vid_ack.
REQ-007 vid_pix_addr  in  13  VRAM offset of pixel byte, valid while vid_req.
REQ-008 vid_attr_addr  in  13  VRAM offset of attribute byte, valid while vid_req.
REQ-009 vid_ack  out  1  one-cycle pulse: request accepted, addresses sampled.
REQ-010 vid_pix, vid_attr  out  8 each  fetched bytes, valid when vid_valid.
REQ-011 vid_valid  out  1  one-cycle pulse: vid_pix/vid_attr valid.
REQ-012 cpu_wr_stb  in  1  one-cycle pulse: synchronized Z80 memory write detected.
REQ-013 cpu_addr  in  16, cpu_data  in  8  write address/data, valid with cpu_wr_stb.
REQ-014 cpu_overflow  out  1  sticky: an in-range write was dropped.
REQ-015 wr_toggle  out  1  inverts on every VRAM write performed (LED drive).
REQ-016 mem_addr  out  13, mem_we  out  1, mem_wdata  out  8  single-port VRAM port.
REQ-017 mem_rdata  in  8  VRAM read data, exactly 1 cycle after mem_addr presented with mem_we=0.

Function
REQ-018 Strobes with cpu_addr outside VRAM_BASE..VRAM_TOP inclusive SHALL be ignored (no push, no overflow).
REQ-019 In-range strobes SHALL push {cpu_addr - VRAM_BASE truncated to 13 bits, cpu_data} into a FIFO of FIFO_DEPTH entries.
REQ-020 Push when full SHALL be dropped and set cpu_overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-021 FSM states: IDLE, VPIX, VATTR, VCAP, CWR.
REQ-022 IDLE: if vid_req -> VPIX; else if FIFO non-empty -> CWR; else stay.
REQ-023 VPIX (cycle n): mem_addr=vid_pix_addr, mem_we=0, vid_ack=1, vid_attr_addr latched; -> VATTR.
REQ-024 VATTR (n+1): mem_addr=latched attr addr, mem_we=0; vid_pix register captures mem_rdata; -> VCAP.
REQ-025 VCAP (n+2): vid_attr register captures mem_rdata; vid_valid=1 at n+3; -> CWR if FIFO non-empty, else VPIX if vid_req, else IDLE.
REQ-026 CWR: pop head, mem_addr=entry offset, mem_wdata=entry data, mem_we=1, toggle wr_toggle; -> VPIX if vid_req, else CWR if FIFO still non-empty, else IDLE.
REQ-027 Fairness: after every VCAP with FIFO non-empty, exactly one CWR SHALL precede the next VPIX; worst-case write wait per entry 4 cycles times position in FIFO.
REQ-028 mem_we SHALL be 1 only in CWR; mem_addr SHALL be 0 in IDLE.
REQ-029 vid_ack and vid_valid SHALL never be high in the same cycle as each other for different fetches except back-to-back VPIX at n+3 (permitted).
REQ-030 FIFO order SHALL be preserved; writes to the same offset land in strobe order.

Reset
REQ-031 On RST, next state SHALL be IDLE, FIFO empty, cpu_overflow=0, wr_toggle=0, vid_ack=0, vid_valid=0, vid_pix=0, vid_attr=0, mem_we=0, mem_addr=0.
REQ-032 RST mid-fetch SHALL abandon it with no vid_valid; RST mid-write SHALL drop remaining FIFO entries; cpu_wr_stb during RST SHALL be ignored.

Structure
REQ-033 Package zx_vram_pkg SHALL hold VRAM_BASE, VRAM_TOP, VRAM_SIZE (6912), ATTR_BASE (13'h1800) and the FSM state type.
REQ-034 The write buffer SHALL be sub-module zx_wr_fifo (synchronous, count-based full/empty, simultaneous push/pop).

Verification
REQ-035 Strobe addr 16'h4000 data 8'hA5 while idle -> CWR within 2 cycles, mem_addr=0, mem_wdata=A5, mem_we=1, wr_toggle flips.
REQ-036 Strobes at 16'h3FFF and 16'h5B00 -> no mem_we, cpu_overflow stays 0.
REQ-037 vid_req pix 13'h0000 attr 13'h1800 with RAM holding 8'hFF/8'h47 -> vid_ack at n, vid_valid at n+3 with vid_pix=FF, vid_attr=47.
REQ-038 vid_req held continuously plus 3 strobes -> fetches and writes alternate VPIX,VATTR,VCAP,CWR; all 3 written within 12 cycles.
REQ-039 6 in-range strobes on consecutive cycles, vid_req held, FIFO_DEPTH=4 -> 4 or 5 accepted per REQ-020, cpu_overflow=1, drops not written.
REQ-040 RST asserted at VATTR -> no vid_valid, state IDLE next cycle, FIFO empty.
